// File: rtl/qspi_flash_responder.sv
// Quad-I/O (0xEB) flash target: decodes command/address/mode/dummy phases and
// streams bytes from a byte-wide backing memory back to the initiator as nibbles.
module qspi_flash_responder #(
    parameter int         ADDR_W       = 24,
    parameter logic [7:0] CMD_QIOR     = 8'hEB,
    parameter int         DUMMY_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck_i,
    input  logic              ce_n_i,
    input  logic [3:0]        io_i,
    output logic [3:0]        io_o,
    output logic              io_oe,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              xip_mode
);

    localparam int BC_W     = 8;
    localparam int ADDR_NIB = ADDR_W / 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_MODE,
        S_DUMMY,
        S_DATA,
        S_IGNORE
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [BC_W-1:0]     r_bc;
    logic                r_ce_q;
    logic [6:0]          r_cmd;
    logic [ADDR_W-5:0]   r_addr;
    logic [1:0]          r_mode;
    logic [7:0]          r_buf;
    logic                r_fetch_q;

    logic                w_bit;
    logic                w_abort;
    logic [7:0]          w_cmd_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic [7:0]          w_next_byte;
    logic                w_cmd_last;
    logic                w_addr_last;
    logic                w_mode_last;
    logic                w_dummy_last;

    assign w_bit        = !ce_n_i && sck_i;
    assign w_abort      = ce_n_i && (r_state != S_IDLE);
    assign w_cmd_nxt    = {r_cmd, io_i[0]};
    assign w_addr_nxt   = {r_addr, io_i};
    // A fetch landing this very cycle is newer than the buffer contents.
    assign w_next_byte  = r_fetch_q ? mem_rdata : r_buf;
    assign w_cmd_last   = (r_bc == BC_W'(7));
    assign w_addr_last  = (r_bc == BC_W'(ADDR_NIB - 1));
    assign w_mode_last  = (r_bc == BC_W'(1));
    assign w_dummy_last = (r_bc == BC_W'(DUMMY_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (ce_n_i) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_ce_q) w_state_nxt = xip_mode ? S_ADDR : S_CMD;
                end
                S_CMD: begin
                    if (w_bit && w_cmd_last)
                        w_state_nxt = (w_cmd_nxt == CMD_QIOR) ? S_ADDR : S_IGNORE;
                end
                S_ADDR: begin
                    if (w_bit && w_addr_last) w_state_nxt = S_MODE;
                end
                S_MODE: begin
                    if (w_bit && w_mode_last) w_state_nxt = S_DUMMY;
                end
                S_DUMMY: begin
                    if (w_bit && w_dummy_last) w_state_nxt = S_DATA;
                end
                S_DATA:   w_state_nxt = S_DATA;
                S_IGNORE: w_state_nxt = S_IGNORE;
                default:  w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ce_q    <= 1'b1;
            r_bc      <= '0;
            r_cmd     <= '0;
            r_addr    <= '0;
            r_mode    <= '0;
            r_buf     <= '0;
            r_fetch_q <= 1'b0;
            io_o      <= '0;
            io_oe     <= 1'b0;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            xip_mode  <= 1'b0;
        end else begin
            r_ce_q    <= ce_n_i;
            mem_rd    <= 1'b0;
            r_fetch_q <= mem_rd;
            if (r_fetch_q) r_buf <= mem_rdata;

            if (w_state_nxt != r_state) begin
                r_bc <= '0;
            end else if (w_bit) begin
                r_bc <= r_bc + BC_W'(1);
            end

            // Abort takes precedence over a bit-time in the same cycle and drops any in-flight fetch.
            if (w_abort) begin
                io_o      <= '0;
                io_oe     <= 1'b0;
                r_fetch_q <= 1'b0;
            end else if (w_bit) begin
                case (r_state)
                    S_CMD: r_cmd <= w_cmd_nxt[6:0];
                    S_ADDR: begin
                        r_addr <= w_addr_nxt[ADDR_W-5:0];
                        if (w_addr_last) begin
                            mem_rd   <= 1'b1;
                            mem_addr <= w_addr_nxt;
                        end
                    end
                    S_MODE: begin
                        r_mode <= io_i[1:0];
                        if (w_mode_last) xip_mode <= (r_mode == 2'b10);
                    end
                    S_DUMMY: begin
                        if (w_dummy_last) begin
                            io_o  <= w_next_byte[7:4];
                            io_oe <= 1'b1;
                        end
                    end
                    S_DATA: begin
                        if (!r_bc[0]) begin
                            io_o <= w_next_byte[3:0];
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                            mem_rd   <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end else if (r_state == S_DATA && r_fetch_q) begin
                io_o <= mem_rdata[7:4];
            end
        end
    end

endmodule

// File: tb/tb_qspi_flash_responder.sv
// Directed bench for qspi_flash_responder: an initiator model drives 0xEB frames,
// a queue scoreboard holds expected data bytes and memory fetch addresses.
module tb_qspi_flash_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        sck_i;
    logic        ce_n_i;
    logic [3:0]  io_i;
    logic [3:0]  io_o;
    logic        io_oe;
    logic        mem_rd;
    logic [23:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        xip_mode;

    int checks = 0;
    int errors = 0;
    int oe_cnt = 0;

    logic [7:0]  exp_q[$];
    logic [23:0] exp_addr_q[$];
    logic [23:0] rd_log[$];
    logic [3:0]  s_io;
    logic        s_oe;

    qspi_flash_responder #(
        .ADDR_W(24),
        .CMD_QIOR(8'hEB),
        .DUMMY_CYCLES(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sck_i(sck_i),
        .ce_n_i(ce_n_i),
        .io_i(io_i),
        .io_o(io_o),
        .io_oe(io_oe),
        .mem_rd(mem_rd),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .xip_mode(xip_mode)
    );

    always #5 clk = ~clk;

    // Backing memory: mem[a] = a[7:0], one cycle read latency.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_addr[7:0];
    end

    always @(negedge clk) begin
        if (mem_rd === 1'b1) rd_log.push_back(mem_addr);
        if (io_oe === 1'b1) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bit_time(input logic [3:0] nib);
        sck_i = 1'b1;
        io_i  = nib;
        @(negedge clk);
        s_io = io_o;
        s_oe = io_oe;
        tick();
        sck_i = 1'b0;
        io_i  = 4'h0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic send_cmd(input logic [7:0] c);
        for (int i = 7; i >= 0; i--) bit_time({3'b000, c[i]});
    endtask

    task automatic send_addr(input logic [23:0] a);
        for (int i = 5; i >= 0; i--) bit_time(a[i*4 +: 4]);
    endtask

    task automatic send_mode_dummy(input logic [7:0] m);
        bit_time(m[7:4]);
        bit_time(m[3:0]);
        repeat (4) bit_time(4'h0);
    endtask

    task automatic start_frame();
        // sck activity with chip enable high must be ignored
        sck_i = 1'b1;
        tick();
        sck_i = 1'b0;
        tick();
        ce_n_i = 1'b0;
        tick();
    endtask

    task automatic end_frame();
        ce_n_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic push_range(input logic [23:0] base, input int nbytes);
        logic [23:0] a;
        for (int i = 0; i <= nbytes; i++) begin
            a = base + 24'(i);
            if (i < nbytes) exp_q.push_back(a[7:0]);
            exp_addr_q.push_back(a);
        end
    endtask

    task automatic read_bytes(input int n);
        logic [3:0] hi;
        logic       oe_hi;
        logic [7:0] exp;
        for (int k = 0; k < n; k++) begin
            bit_time(4'h0);
            hi    = s_io;
            oe_hi = s_oe;
            bit_time(4'h0);
            check("data_oe", {30'b0, oe_hi, s_oe}, 32'h3);
            if (exp_q.size() != 0) exp = exp_q.pop_front();
            else exp = 8'hxx;
            check("data_byte", {24'b0, hi, s_io}, {24'b0, exp});
        end
    endtask

    task automatic check_fetches();
        check("fetch_count", rd_log.size(), exp_addr_q.size());
        while (rd_log.size() != 0 && exp_addr_q.size() != 0)
            check("fetch_addr", {8'b0, rd_log.pop_front()}, {8'b0, exp_addr_q.pop_front()});
        rd_log.delete();
        exp_addr_q.delete();
    endtask

    initial begin
        rst    = 1'b1;
        sck_i  = 1'b0;
        ce_n_i = 1'b1;
        io_i   = 4'h0;
        repeat (3) tick();
        check("rst_io_o", {28'b0, io_o}, 32'h0);
        check("rst_io_oe", {31'b0, io_oe}, 32'h0);
        check("rst_mem_rd", {31'b0, mem_rd}, 32'h0);
        check("rst_mem_addr", {8'b0, mem_addr}, 32'h0);
        check("rst_xip", {31'b0, xip_mode}, 32'h0);
        rst = 1'b0;
        tick();

        // EB read of 16 bytes at 0x10 with mode A5 -> continuous-read mode
        push_range(24'h000010, 16);
        start_frame();
        send_cmd(8'hEB);
        send_addr(24'h000010);
        send_mode_dummy(8'hA5);
        read_bytes(16);
        end_frame();
        check("t1_xip", {31'b0, xip_mode}, 32'h1);
        check_fetches();

        // Continuous-read frame: no command byte
        push_range(24'h000020, 16);
        start_frame();
        send_addr(24'h000020);
        send_mode_dummy(8'hA5);
        read_bytes(16);
        end_frame();
        check("t2_xip", {31'b0, xip_mode}, 32'h1);
        check_fetches();

        // Mode 00 leaves continuous-read mode
        push_range(24'h000040, 2);
        start_frame();
        send_addr(24'h000040);
        send_mode_dummy(8'h00);
        read_bytes(2);
        end_frame();
        check("t3_xip_off", {31'b0, xip_mode}, 32'h0);
        check_fetches();

        // Commandless frame now decodes address nibbles as a command -> ignored
        oe_cnt = 0;
        rd_log.delete();
        start_frame();
        send_addr(24'h000020);
        send_mode_dummy(8'hA5);
        repeat (4) bit_time(4'h0);
        end_frame();
        check("t3_ignore_oe", oe_cnt, 0);
        check("t3_ignore_rd", rd_log.size(), 0);
        check("t3_ignore_xip", {31'b0, xip_mode}, 32'h0);

        // Unsupported command 0x03
        oe_cnt = 0;
        rd_log.delete();
        start_frame();
        send_cmd(8'h03);
        send_addr(24'h000050);
        send_mode_dummy(8'hA5);
        repeat (4) bit_time(4'h0);
        end_frame();
        check("t4_ignore_oe", oe_cnt, 0);
        check("t4_ignore_rd", rd_log.size(), 0);

        push_range(24'h000080, 2);
        start_frame();
        send_cmd(8'hEB);
        send_addr(24'h000080);
        send_mode_dummy(8'h00);
        read_bytes(2);
        end_frame();
        check_fetches();

        // Address wrap at the top of the space
        push_range(24'hFFFFFE, 4);
        start_frame();
        send_cmd(8'hEB);
        send_addr(24'hFFFFFE);
        send_mode_dummy(8'h00);
        read_bytes(4);
        end_frame();
        check_fetches();

        // Abort after the high nibble of the third byte
        push_range(24'h000100, 2);
        start_frame();
        send_cmd(8'hEB);
        send_addr(24'h000100);
        send_mode_dummy(8'hA5);
        read_bytes(2);
        bit_time(4'h0);
        check("t6_hi_nib", {27'b0, s_oe, s_io}, 32'h10);
        check("t6_lo_pending", {28'b0, io_o}, 32'h2);
        ce_n_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("t6_abort_oe", {31'b0, io_oe}, 32'h0);
        check("t6_abort_io", {28'b0, io_o}, 32'h0);
        tick();
        check("t6_abort_xip", {31'b0, xip_mode}, 32'h1);
        check_fetches();

        // Reset during DATA
        push_range(24'h000030, 1);
        start_frame();
        send_addr(24'h000030);
        send_mode_dummy(8'hA5);
        read_bytes(1);
        bit_time(4'h0);
        check_fetches();
        check("t6_pre_rst_oe", {31'b0, io_oe}, 32'h1);
        rst = 1'b1;
        #1;
        check("t6_rst_oe", {31'b0, io_oe}, 32'h0);
        check("t6_rst_io", {28'b0, io_o}, 32'h0);
        check("t6_rst_rd", {31'b0, mem_rd}, 32'h0);
        check("t6_rst_addr", {8'b0, mem_addr}, 32'h0);
        check("t6_rst_xip", {31'b0, xip_mode}, 32'h0);
        ce_n_i = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("sb_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
